// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle around mem_port_arbiter: fetch port, data port and shared memory port.
// The master modport is the arbiter's view; the slave modport is the view of its neighbours.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wstrobe;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [3:0]  m_wstrobe;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  logic        err;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_wstrobe, d_addr, d_wdata, m_ack, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_wstrobe, m_addr, m_wdata, err
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_wstrobe, d_addr, d_wdata, m_ack, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_wstrobe, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port, one outstanding transaction at a time,
// with optional round-robin and a per-transaction timeout that completes the owner with zero data.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter bit          RR_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT);

  state_t      state, state_next;
  logic        owner_d, last_d;
  logic        lat_we;
  logic [3:0]  lat_wstrobe;
  logic [31:0] lat_addr, lat_wdata;
  logic [15:0] tmo_cnt;

  logic        tmo_hit, grant, grant_d, complete, timeout, pass_rdata, finish;

  // tmo_cnt+1 is the number of busy cycles including the current one.
  assign tmo_hit = ({1'b0, tmo_cnt} + 17'd1) >= TIMEOUT_LIMIT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Arbitration in IDLE, completion/timeout detection while busy; completion beats timeout.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_d    = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    pass_rdata = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && (bus.i_req || bus.d_req)) begin
          grant      = 1'b1;
          grant_d    = bus.d_req && (!bus.i_req || !RR_EN || !last_d);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ack && (lat_we || bus.m_rvalid)) begin
          complete   = 1'b1;
          pass_rdata = !lat_we;
          state_next = IDLE;
        end else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else if (bus.m_ack) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.m_rvalid) begin
          complete   = 1'b1;
          pass_rdata = 1'b1;
          state_next = IDLE;
        end else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetches are latched as full-word reads so the memory side sees a uniform command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_d     <= 1'b0;
      last_d      <= 1'b0;
      lat_we      <= 1'b0;
      lat_wstrobe <= 4'h0;
      lat_addr    <= 32'h0;
      lat_wdata   <= 32'h0;
      tmo_cnt     <= 16'h0;
    end else if (grant) begin
      owner_d <= grant_d;
      last_d  <= grant_d;
      tmo_cnt <= 16'h0;
      if (grant_d) begin
        lat_we      <= bus.d_we;
        lat_wstrobe <= bus.d_wstrobe;
        lat_addr    <= bus.d_addr;
        lat_wdata   <= bus.d_wdata;
      end else begin
        lat_we      <= 1'b0;
        lat_wstrobe <= 4'hF;
        lat_addr    <= bus.i_addr;
        lat_wdata   <= 32'h0;
      end
    end else if (state != IDLE) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign finish = complete | timeout;

  assign bus.i_gnt     = grant & ~grant_d;
  assign bus.d_gnt     = grant & grant_d;
  assign bus.i_rvalid  = finish & ~owner_d;
  assign bus.d_rvalid  = finish & owner_d;
  assign bus.i_rdata   = (pass_rdata && !owner_d) ? bus.m_rdata : 32'h0;
  assign bus.d_rdata   = (pass_rdata && owner_d) ? bus.m_rdata : 32'h0;
  assign bus.err       = timeout;

  assign bus.m_req     = (state == ISSUE);
  assign bus.m_we      = lat_we;
  assign bus.m_wstrobe = lat_wstrobe;
  assign bus.m_addr    = lat_addr;
  assign bus.m_wdata   = lat_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random
// traffic, all continuously compared against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(TMO), .RR_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: one outstanding transaction described by owner, fields, age and whether it was accepted.
  bit        mdl_busy, mdl_own_d, mdl_wr, mdl_acked, mdl_last_d;
  bit [31:0] mdl_addr, mdl_wdata;
  bit [3:0]  mdl_wstrobe;
  int        mdl_age;
  bit        seen_i_gnt, seen_d_gnt;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ack, input logic rvalid, input logic [31:0] rdata);
    bus.m_ack    = ack;
    bus.m_rvalid = rvalid;
    bus.m_rdata  = rdata;
  endtask

  // Compare process: expectations are derived from the model and the inputs seen this cycle.
  always @(negedge clk) begin
    bit        e_ig, e_dg, e_iv, e_dv, e_err, e_mreq, done, expired, win_d;
    bit [31:0] e_ird, e_drd;
    e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_err = 0; e_mreq = 0;
    done = 0; expired = 0; win_d = 0; e_ird = 0; e_drd = 0;
    if (reset) begin
      checkOutput("rst_m_req", bus.m_req, 0);
      checkOutput("rst_m_we", bus.m_we, 0);
      checkOutput("rst_m_wstrobe", bus.m_wstrobe, 0);
      checkOutput("rst_m_addr", bus.m_addr, 0);
      checkOutput("rst_m_wdata", bus.m_wdata, 0);
      checkOutput("rst_i_gnt", bus.i_gnt, 0);
      checkOutput("rst_d_gnt", bus.d_gnt, 0);
      checkOutput("rst_i_rvalid", bus.i_rvalid, 0);
      checkOutput("rst_d_rvalid", bus.d_rvalid, 0);
      checkOutput("rst_i_rdata", bus.i_rdata, 0);
      checkOutput("rst_d_rdata", bus.d_rdata, 0);
      checkOutput("rst_err", bus.err, 0);
      mdl_busy = 0; mdl_last_d = 0; mdl_acked = 0; mdl_age = 0;
      seen_i_gnt = 0; seen_d_gnt = 0;
    end else begin
      if (!mdl_busy) begin
        if (bus.i_req && bus.d_req) win_d = !mdl_last_d;
        else                        win_d = bus.d_req;
        e_ig = bus.i_req && !win_d;
        e_dg = win_d;
      end else begin
        e_mreq  = !mdl_acked;
        done    = mdl_acked ? bus.m_rvalid : (bus.m_ack && (mdl_wr || bus.m_rvalid));
        expired = !done && (mdl_age + 1 >= TMO);
        if (done || expired) begin
          if (mdl_own_d) begin
            e_dv = 1;
            if (done && !mdl_wr) e_drd = bus.m_rdata;
          end else begin
            e_iv = 1;
            if (done) e_ird = bus.m_rdata;
          end
          e_err = expired;
        end
      end
      checkOutput("i_gnt", bus.i_gnt, e_ig);
      checkOutput("d_gnt", bus.d_gnt, e_dg);
      checkOutput("m_req", bus.m_req, e_mreq);
      checkOutput("i_rvalid", bus.i_rvalid, e_iv);
      checkOutput("d_rvalid", bus.d_rvalid, e_dv);
      checkOutput("i_rdata", bus.i_rdata, e_ird);
      checkOutput("d_rdata", bus.d_rdata, e_drd);
      checkOutput("err", bus.err, e_err);
      if (e_mreq) begin
        checkOutput("m_addr", bus.m_addr, mdl_addr);
        checkOutput("m_we", bus.m_we, mdl_wr);
        checkOutput("m_wstrobe", bus.m_wstrobe, mdl_wstrobe);
        checkOutput("m_wdata", bus.m_wdata, mdl_wdata);
      end
      if (!mdl_busy) begin
        if (e_ig || e_dg) begin
          mdl_busy    = 1;
          mdl_own_d   = e_dg;
          mdl_last_d  = e_dg;
          mdl_acked   = 0;
          mdl_age     = 0;
          mdl_wr      = e_dg ? bus.d_we : 1'b0;
          mdl_addr    = e_dg ? bus.d_addr : bus.i_addr;
          mdl_wstrobe = e_dg ? bus.d_wstrobe : 4'hF;
          mdl_wdata   = e_dg ? bus.d_wdata : 32'h0;
        end
      end else begin
        mdl_age++;
        if (done || expired)             mdl_busy  = 0;
        else if (!mdl_acked && bus.m_ack) mdl_acked = 1;
      end
      seen_i_gnt = e_ig;
      seen_d_gnt = e_dg;
    end
  end

  initial begin
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_wstrobe = 0; bus.d_addr = 0; bus.d_wdata = 0;
    applyStimulus(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 0;

    // Single fetch completing with ack and rvalid together.
    bus.i_req = 1; bus.i_addr = 32'h8000_0000;
    @(negedge clk);
    checkOutput("fetch_i_gnt", bus.i_gnt, 1'b1);
    checkOutput("fetch_m_req_c0", bus.m_req, 1'b0);
    nextCycle(); bus.i_req = 0; applyStimulus(1, 1, 32'h0000_0013);
    @(negedge clk);
    checkOutput("fetch_m_req_c1", bus.m_req, 1'b1);
    checkOutput("fetch_m_addr", bus.m_addr, 32'h8000_0000);
    checkOutput("fetch_m_wstrobe", bus.m_wstrobe, 32'hF);
    checkOutput("fetch_i_rvalid", bus.i_rvalid, 1'b1);
    checkOutput("fetch_i_rdata", bus.i_rdata, 32'h0000_0013);
    nextCycle(); applyStimulus(0, 0, 0);

    // Contention after reset: data, then fetch, then data again.
    reset = 1;
    nextCycle(); reset = 0;
    bus.i_req = 1; bus.i_addr = 32'h40; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    @(negedge clk);
    checkOutput("rr1_d_gnt", bus.d_gnt, 1'b1);
    checkOutput("rr1_i_gnt", bus.i_gnt, 1'b0);
    nextCycle(); applyStimulus(1, 1, 32'h11);
    @(negedge clk);
    checkOutput("rr1_d_rvalid", bus.d_rvalid, 1'b1);
    nextCycle(); applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("rr2_i_gnt", bus.i_gnt, 1'b1);
    checkOutput("rr2_d_gnt", bus.d_gnt, 1'b0);
    nextCycle(); applyStimulus(1, 1, 32'h22);
    nextCycle(); applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("rr3_d_gnt", bus.d_gnt, 1'b1);
    nextCycle(); bus.i_req = 0; bus.d_req = 0; applyStimulus(1, 1, 32'h33);
    nextCycle(); applyStimulus(0, 0, 0);

    // Byte-masked write with a late ack; completion lands exactly on the timeout cycle.
    bus.d_req = 1; bus.d_we = 1; bus.d_wstrobe = 4'b0011; bus.d_addr = 32'h200; bus.d_wdata = 32'hAAAA_5555;
    @(negedge clk);
    checkOutput("wr_d_gnt", bus.d_gnt, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      nextCycle(); bus.d_req = 0;
      @(negedge clk);
      checkOutput("wr_m_req", bus.m_req, 1'b1);
      checkOutput("wr_m_we", bus.m_we, 1'b1);
      checkOutput("wr_m_wstrobe", bus.m_wstrobe, 32'h3);
      checkOutput("wr_m_wdata", bus.m_wdata, 32'hAAAA_5555);
    end
    nextCycle(); applyStimulus(1, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("wr_d_rvalid", bus.d_rvalid, 1'b1);
    checkOutput("wr_d_rdata", bus.d_rdata, 32'h0);
    checkOutput("wr_i_rvalid", bus.i_rvalid, 1'b0);
    checkOutput("wr_err", bus.err, 1'b0);
    nextCycle(); applyStimulus(0, 0, 0); bus.d_we = 0;

    // Split read: accepted on cycle 1, data on cycle 4.
    bus.d_req = 1; bus.d_addr = 32'h300;
    @(negedge clk);
    checkOutput("split_d_gnt", bus.d_gnt, 1'b1);
    nextCycle(); bus.d_req = 0; applyStimulus(1, 0, 0);
    nextCycle(); applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("split_m_req_c2", bus.m_req, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("split_d_rvalid_c3", bus.d_rvalid, 1'b0);
    nextCycle(); applyStimulus(0, 1, 32'h1234_5678);
    @(negedge clk);
    checkOutput("split_d_rvalid", bus.d_rvalid, 1'b1);
    checkOutput("split_d_rdata", bus.d_rdata, 32'h1234_5678);
    checkOutput("split_m_req_c4", bus.m_req, 1'b0);
    nextCycle(); applyStimulus(0, 0, 0);

    // Timeout on a fetch with a data request waiting behind it.
    bus.i_req = 1; bus.i_addr = 32'h400; bus.d_req = 1; bus.d_addr = 32'h500;
    @(negedge clk);
    checkOutput("tmo_i_gnt", bus.i_gnt, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      nextCycle(); bus.i_req = 0;
      @(negedge clk);
      checkOutput("tmo_err_early", bus.err, 1'b0);
    end
    nextCycle();
    @(negedge clk);
    checkOutput("tmo_err", bus.err, 1'b1);
    checkOutput("tmo_i_rvalid", bus.i_rvalid, 1'b1);
    checkOutput("tmo_i_rdata", bus.i_rdata, 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("tmo_next_d_gnt", bus.d_gnt, 1'b1);
    nextCycle(); bus.d_req = 0; applyStimulus(1, 1, 32'h55);
    @(negedge clk);
    checkOutput("tmo_next_d_rdata", bus.d_rdata, 32'h55);
    nextCycle(); applyStimulus(0, 0, 0);

    // Reset while waiting for read data, then a stale m_rvalid.
    bus.i_req = 1; bus.i_addr = 32'h600;
    @(negedge clk);
    checkOutput("rstw_i_gnt", bus.i_gnt, 1'b1);
    nextCycle(); bus.i_req = 0; applyStimulus(1, 0, 0);
    nextCycle(); applyStimulus(0, 0, 0);
    nextCycle(); reset = 1;
    #1;
    checkOutput("rstw_async_m_req", bus.m_req, 1'b0);
    checkOutput("rstw_async_m_addr", bus.m_addr, 32'h0);
    nextCycle(); reset = 0; applyStimulus(0, 1, 32'hCAFE);
    @(negedge clk);
    checkOutput("rstw_i_rvalid", bus.i_rvalid, 1'b0);
    checkOutput("rstw_err", bus.err, 1'b0);
    nextCycle(); applyStimulus(0, 0, 0); bus.d_req = 1; bus.d_addr = 32'h700;
    @(negedge clk);
    checkOutput("rstw_new_d_gnt", bus.d_gnt, 1'b1);
    nextCycle(); bus.d_req = 0; applyStimulus(1, 1, 32'h77);
    @(negedge clk);
    checkOutput("rstw_new_d_rdata", bus.d_rdata, 32'h77);
    nextCycle(); applyStimulus(0, 0, 0);

    // Random traffic with occasional abandoned requests and resets.
    for (int n = 0; n < 3000; n++) begin
      nextCycle();
      if (reset)               reset = 1'b0;
      else if (n % 750 == 700) reset = 1'b1;
      if (!bus.i_req || seen_i_gnt) begin
        bus.i_req  = ($urandom_range(99) < 45);
        bus.i_addr = $urandom();
      end else if ($urandom_range(99) < 4) begin
        bus.i_req = 1'b0;
      end
      if (!bus.d_req || seen_d_gnt) begin
        bus.d_req     = ($urandom_range(99) < 45);
        bus.d_we      = $urandom_range(1);
        bus.d_wstrobe = 4'($urandom_range(15));
        bus.d_addr    = $urandom();
        bus.d_wdata   = $urandom();
      end else if ($urandom_range(99) < 4) begin
        bus.d_req = 1'b0;
      end
      applyStimulus($urandom_range(99) < 40, $urandom_range(99) < 35, $urandom());
    end

    nextCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
